// File: rtl/xgmii64_frame_arbiter_pkg.sv
// Shared types and constants for the two-requester XGMII 64-bit frame arbiter.
package xgmii64_frame_arbiter_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;

    typedef struct packed {
        logic        ena;
        logic [7:0]  ctrl;
        logic [63:0] data;
    } xgmii64_t;

    localparam xgmii64_t XGMII64_IDLE = '{ena: 1'b1, ctrl: 8'hFF, data: {8{XGMII_IDLE}}};
    // Output value while in reset: idle content but not marked valid.
    localparam xgmii64_t XGMII64_RST  = '{ena: 1'b0, ctrl: 8'hFF, data: {8{XGMII_IDLE}}};

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } arb_state_t;

endpackage

// File: rtl/xgmii64_frame_arbiter_if.sv
// Bundles the requester columns, ready strobes, arbitrated column and grant.
interface xgmii64_frame_arbiter_if;
    import xgmii64_frame_arbiter_pkg::*;

    xgmii64_t   xgmii_in [2];
    logic [1:0] in_rdy;
    xgmii64_t   xgmii_out;
    logic [1:0] grant;

    modport master (output xgmii_in, input in_rdy, input xgmii_out, input grant);
    modport slave  (input xgmii_in, output in_rdy, output xgmii_out, output grant);

endinterface

// File: rtl/xgmii64_frame_arbiter_col_classify.sv
// Combinational classification of one 64-bit XGMII column into start/term/idle.
module xgmii64_col_classify
    import xgmii64_frame_arbiter_pkg::*;
(
    input  xgmii64_t col,
    output logic     is_start,
    output logic     is_term,
    output logic     is_idle
);

    logic [7:0] lane_term;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign lane_term[gi] = col.ctrl[gi] & (col.data[8*gi +: 8] == XGMII_TERM);
    end

    // Starts are only legal in lane 0 or lane 4 of a 64-bit column.
    assign is_start = (col.ctrl[0] & (col.data[7:0]   == XGMII_START)) |
                      (col.ctrl[4] & (col.data[39:32] == XGMII_START));
    assign is_term  = |lane_term;
    assign is_idle  = (col.ctrl == 8'hFF) & (col.data == {8{XGMII_IDLE}});

endmodule

// File: rtl/xgmii64_frame_arbiter.sv
// Round-robin frame arbiter for two XGMII 64-bit requesters with idle fill and IPG.
// Optional per-requester frame/drop counters are enabled by XGMII_ARB_STATS_EN.
module xgmii64_frame_arbiter
    import xgmii64_frame_arbiter_pkg::*;
#(
    parameter int IPG_COLS = 1,
    parameter int NREQ     = 2
)(
    input  logic                    clk_64,
    input  logic                    rst_64_n,
    xgmii64_frame_arbiter_if.slave  bus
`ifdef XGMII_ARB_STATS_EN
    ,
    output logic [31:0]             frame_cnt [2],
    output logic [31:0]             drop_cnt  [2]
`endif
);

    localparam int GW = (IPG_COLS > 1) ? $clog2(IPG_COLS) : 1;

    if (NREQ != 2) begin : g_nreq_chk
        $error("xgmii64_frame_arbiter supports exactly two requesters");
    end
    if (IPG_COLS < 1) begin : g_ipg_chk
        $error("xgmii64_frame_arbiter needs IPG_COLS >= 1");
    end

    logic [1:0] vld, start, term, idle;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic cls_start, cls_term, cls_idle;

        xgmii64_col_classify u_classify (
            .col      (bus.xgmii_in[gi]),
            .is_start (cls_start),
            .is_term  (cls_term),
            .is_idle  (cls_idle)
        );

        assign vld[gi]   = bus.xgmii_in[gi].ena;
        assign start[gi] = bus.xgmii_in[gi].ena & cls_start;
        assign term[gi]  = bus.xgmii_in[gi].ena & cls_term;
        assign idle[gi]  = cls_idle;
    end

    arb_state_t    state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          gidx_q, gidx_d;
    logic [1:0]    grant_q, grant_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    xgmii64_t      out_q, out_d;

    logic [1:0]    rdy, fwd;
    logic          take, g, g_pick;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = XGMII64_IDLE;
        rdy       = vld & ~start;
        fwd       = 2'b00;
        take      = 1'b0;
        g         = gidx_q;
        g_pick    = (start == 2'b11) ? ~rr_ptr_q : start[1];

        case (state_q)
            IDLE: begin
                if (|start) begin
                    g       = g_pick;
                    gidx_d  = g_pick;
                    take    = 1'b1;
                    state_d = FRAME;
                end
            end
            FRAME: begin
                take = 1'b1;
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The owner's column is forwarded untouched, bubbles (ena=0) included.
        if (take) begin
            rdy[g]  = 1'b1;
            fwd[g]  = vld[g];
            out_d   = g ? bus.xgmii_in[1] : bus.xgmii_in[0];
            grant_d = g ? 2'b10 : 2'b01;
            if (term[g]) begin
                state_d   = GAP;
                grant_d   = 2'b00;
                rr_ptr_d  = g;
                gap_cnt_d = GW'(IPG_COLS - 1);
            end
        end
    end

    always_ff @(posedge clk_64 or negedge rst_64_n) begin
        if (!rst_64_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            gidx_q    <= 1'b0;
            grant_q   <= 2'b00;
            gap_cnt_q <= '0;
            out_q     <= XGMII64_RST;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
        end
    end

    // Ready is combinational, so it is forced low while reset is held.
    assign bus.in_rdy    = rst_64_n ? rdy : 2'b00;
    assign bus.xgmii_out = out_q;
    assign bus.grant     = grant_q;

`ifdef XGMII_ARB_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        logic [31:0] frame_cnt_q, frame_cnt_d;
        logic [31:0] drop_cnt_q, drop_cnt_d;

        assign frame_cnt_d = frame_cnt_q + {31'b0, fwd[gi] & term[gi]};
        assign drop_cnt_d  = drop_cnt_q +
                             {31'b0, rdy[gi] & vld[gi] & ~fwd[gi] & ~idle[gi]};

        always_ff @(posedge clk_64 or negedge rst_64_n) begin
            if (!rst_64_n) begin
                frame_cnt_q <= '0;
                drop_cnt_q  <= '0;
            end else begin
                frame_cnt_q <= frame_cnt_d;
                drop_cnt_q  <= drop_cnt_d;
            end
        end

        assign frame_cnt[gi] = frame_cnt_q;
        assign drop_cnt[gi]  = drop_cnt_q;
    end
`else
    logic [1:0] unused_idle;
    assign unused_idle = idle;
`endif

endmodule

// File: tb/tb_xgmii64_frame_arbiter.sv
// Directed, table-driven bench for xgmii64_frame_arbiter (IPG_COLS=1).
module tb_xgmii64_frame_arbiter;
    import xgmii64_frame_arbiter_pkg::*;

    logic clk_64   = 1'b0;
    logic rst_64_n = 1'b0;
    always #5 clk_64 = ~clk_64;

    xgmii64_frame_arbiter_if bus();

`ifdef XGMII_ARB_STATS_EN
    logic [31:0] frame_cnt [2];
    logic [31:0] drop_cnt  [2];
`endif

    xgmii64_frame_arbiter #(.IPG_COLS(1), .NREQ(2)) dut (
        .clk_64    (clk_64),
        .rst_64_n  (rst_64_n),
        .bus       (bus.slave)
`ifdef XGMII_ARB_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    localparam xgmii64_t I  = '{1'b1, 8'hFF, 64'h0707070707070707};
    localparam xgmii64_t O  = '{1'b0, 8'hFF, 64'h0707070707070707};
    localparam xgmii64_t S0 = '{1'b1, 8'h01, 64'h55555555555555FB};
    localparam xgmii64_t D1 = '{1'b1, 8'h00, 64'h0011223344556677};
    localparam xgmii64_t D2 = '{1'b1, 8'h00, 64'h8899AABBCCDDEEFF};
    localparam xgmii64_t T3 = '{1'b1, 8'hF8, 64'h07070707FDA1B2C3};
    localparam xgmii64_t S1 = '{1'b1, 8'h01, 64'hAAAAAAAAAAAAAAFB};
    localparam xgmii64_t E1 = '{1'b1, 8'hFF, 64'h07070707070707FD};
    localparam xgmii64_t SH = '{1'b1, 8'h9F, 64'hFD6655FB07070707};

    typedef struct {
        xgmii64_t   in0;
        xgmii64_t   in1;
        logic [1:0] rdy;
        xgmii64_t   out;
        logic [1:0] gnt;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    function automatic void add(xgmii64_t a, xgmii64_t b, logic [1:0] r,
                                xgmii64_t o, logic [1:0] gn);
        vec_t v;
        v.in0 = a; v.in1 = b; v.rdy = r; v.out = o; v.gnt = gn;
        vecs.push_back(v);
    endfunction

    task automatic chk_col(string nm, xgmii64_t act, xgmii64_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_val(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(xgmii64_t a, xgmii64_t b);
        bus.xgmii_in[0] = a;
        bus.xgmii_in[1] = b;
    endtask

    initial begin
        // Single frame from req0, then exactly one idle before its next start.
        add(S0, O, 2'b01, S0, 2'b01);
        add(D1, O, 2'b01, D1, 2'b01);
        add(D2, O, 2'b01, D2, 2'b01);
        add(T3, O, 2'b01, T3, 2'b00);
        add(S0, O, 2'b00, I,  2'b00);
        add(S0, O, 2'b01, S0, 2'b01);
        add(T3, O, 2'b01, T3, 2'b00);
        add(O,  O, 2'b00, I,  2'b00);
        // Simultaneous starts: req1 first (rr_ptr=0), req0 held, then req0.
        add(S0, S1, 2'b10, S1, 2'b10);
        add(S0, D1, 2'b10, D1, 2'b10);
        add(S0, E1, 2'b10, E1, 2'b00);
        add(S0, O,  2'b00, I,  2'b00);
        add(S0, O,  2'b01, S0, 2'b01);
        // Three bubbles with req1 start held, then a repeated start forwarded as-is.
        add(O,  S1, 2'b01, O,  2'b01);
        add(O,  S1, 2'b01, O,  2'b01);
        add(O,  S1, 2'b01, O,  2'b01);
        add(S0, S1, 2'b01, S0, 2'b01);
        add(T3, S1, 2'b01, T3, 2'b00);
        add(O,  S1, 2'b00, I,  2'b00);
        add(O,  S1, 2'b10, S1, 2'b10);
        add(O,  E1, 2'b10, E1, 2'b00);
        add(O,  O,  2'b00, I,  2'b00);
        // Short frame: start lane 4 and terminate in one column.
        add(SH, O, 2'b01, SH, 2'b00);
        add(O,  O, 2'b00, I,  2'b00);
        // Ungranted req1 idles and orphan data are consumed and dropped.
        for (int k = 0; k < 5; k++) add(O, I, 2'b10, I, 2'b00);
        add(O, D1, 2'b10, I, 2'b00);
        add(O, D2, 2'b10, I, 2'b00);
        // Both starts arrive during GAP: held, then round-robin.
        add(S0, O,  2'b01, S0, 2'b01);
        add(T3, O,  2'b01, T3, 2'b00);
        add(S0, S1, 2'b00, I,  2'b00);
        add(S0, S1, 2'b10, S1, 2'b10);
        add(S0, E1, 2'b10, E1, 2'b00);
        add(S0, O,  2'b00, I,  2'b00);
        add(S0, O,  2'b01, S0, 2'b01);
        add(T3, O,  2'b01, T3, 2'b00);
        add(O,  O,  2'b00, I,  2'b00);

        drive(O, D1);
        repeat (2) @(posedge clk_64);
        #1;
        chk_col("reset_out", bus.xgmii_out, XGMII64_RST);
        chk_val("reset_grant", {30'b0, bus.grant}, 32'd0);
        chk_val("reset_rdy", {30'b0, bus.in_rdy}, 32'd0);
        @(negedge clk_64);
        rst_64_n = 1'b1;
        drive(O, O);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_64);
            drive(vecs[i].in0, vecs[i].in1);
            #1;
            chk_val($sformatf("vec%0d_rdy", i), {30'b0, bus.in_rdy}, {30'b0, vecs[i].rdy});
            @(posedge clk_64);
            #1;
            chk_col($sformatf("vec%0d_out", i), bus.xgmii_out, vecs[i].out);
            chk_val($sformatf("vec%0d_grant", i), {30'b0, bus.grant}, {30'b0, vecs[i].gnt});
            $display("vec %0d in_rdy=%b out=%h grant=%b", i, bus.in_rdy, bus.xgmii_out, bus.grant);
        end

`ifdef XGMII_ARB_STATS_EN
        chk_val("frame_cnt0", frame_cnt[0], 32'd6);
        chk_val("frame_cnt1", frame_cnt[1], 32'd3);
        chk_val("drop_cnt0", drop_cnt[0], 32'd0);
        chk_val("drop_cnt1", drop_cnt[1], 32'd2);
`endif

        // Asynchronous reset in the middle of a frame.
        @(negedge clk_64);
        drive(S0, O);
        @(posedge clk_64); #1;
        chk_col("mid_start_out", bus.xgmii_out, S0);
        @(negedge clk_64);
        drive(D1, O);
        @(posedge clk_64); #1;
        chk_col("mid_data_out", bus.xgmii_out, D1);
        @(negedge clk_64);
        drive(D2, O);
        #2 rst_64_n = 1'b0;
        #1;
        chk_col("async_rst_out", bus.xgmii_out, XGMII64_RST);
        chk_val("async_rst_grant", {30'b0, bus.grant}, 32'd0);
        chk_val("async_rst_rdy", {30'b0, bus.in_rdy}, 32'd0);
        $display("async reset out=%h grant=%b in_rdy=%b", bus.xgmii_out, bus.grant, bus.in_rdy);
`ifdef XGMII_ARB_STATS_EN
        chk_val("async_rst_frame_cnt0", frame_cnt[0], 32'd0);
`endif
        @(negedge clk_64);
        rst_64_n = 1'b1;
        drive(S0, O);
        #1;
        chk_val("post_rst_rdy", {30'b0, bus.in_rdy}, 32'd1);
        @(posedge clk_64); #1;
        chk_col("post_rst_start", bus.xgmii_out, S0);
        chk_val("post_rst_grant", {30'b0, bus.grant}, 32'd1);
        @(negedge clk_64);
        drive(T3, O);
        @(posedge clk_64); #1;
        chk_col("post_rst_term", bus.xgmii_out, T3);
        chk_val("post_rst_grant_drop", {30'b0, bus.grant}, 32'd0);
        @(negedge clk_64);
        drive(O, O);
        @(posedge clk_64); #1;
        chk_col("post_rst_gap", bus.xgmii_out, I);
`ifdef XGMII_ARB_STATS_EN
        chk_val("post_rst_frame_cnt0", frame_cnt[0], 32'd1);
        chk_val("post_rst_drop_cnt1", drop_cnt[1], 32'd0);
`endif
        $display("post reset frame out=%h grant=%b", bus.xgmii_out, bus.grant);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
